spike_packet_encoder: RTL and testbench

// - Transmit side of the neuron array's spike output. At each end-of-timestep strobe it captures
//   the spike_o bits of all NUM_NEURONS neuron blocks as a frame.
// - Sends one packet per set bit, in ascending neuron index, on a valid/ready stream to the

---
 rtl/spike_packet_encoder_pkg.sv | 20 ++
 rtl/spike_priority_encoder.sv | 27 ++
 rtl/spike_packet_encoder.sv | 147 ++++++++++++++
 tb/tb_spike_packet_encoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spike_packet_encoder_pkg.sv
// Shared definitions for the spike packet encoder and its helpers.
// - Default geometry of a core: neuron count, index width, core-id width.
// - Packet layout: neuron index in the low IDX_W bits, core id above it.
// - FSM state encoding shared by the encoder (and anything that probes it).
package spike_packet_encoder_pkg;

  localparam int DEF_NUM_NEURONS = 256;
  localparam int DEF_IDX_W       = 8;
  localparam int DEF_CORE_ID_W   = 8;
  localparam int DEF_PKT_W       = DEF_CORE_ID_W + DEF_IDX_W;

  // Packet field offsets: idx occupies [IDX_W-1:0], core id [PKT_W-1:IDX_W].
  localparam int PKT_IDX_LSB = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/spike_priority_encoder.sv
// Combinational lowest-set-bit finder.
// Ports:
//   vec     in  N      input bit vector
//   idx     out IDX_W  index of the lowest set bit (0 when vec is all zero)
//   any_set out 1      at least one bit of vec is set
// Also used on the router input side, so it carries no encoder-specific logic.
module spike_priority_encoder #(
  parameter int N     = 256,
  parameter int IDX_W = 8
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any_set
);

  // Scan from the top down so the last assignment wins with the lowest index.
  always_comb begin
    idx     = '0;
    any_set = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/spike_packet_encoder.sv
// Transmit side of the neuron array's spike output.
// On an end-of-timestep strobe the spike vector is captured into a shadow
// register and one packet {CORE_ID, neuron_idx} is emitted per set bit, lowest
// index first, over a valid/ready stream.
// Ports:
//   clk             in  1                clock, rising edge
//   reset           in  1                asynchronous active-high reset
//   spike_vec_i     in  NUM_NEURONS      spike bit of neuron i on bit i
//   spike_strobe_i  in  1                capture request (1-cycle pulse)
//   pkt_valid_o     out 1                packet available
//   pkt_ready_i     in  1                downstream accepts when valid & ready
//   pkt_data_o      out CORE_ID_W+IDX_W  {CORE_ID, neuron_idx}
//   pkt_last_o      out 1                final packet of the frame
//   frame_done_o    out 1                1-cycle pulse: frame sent (or empty)
//   busy_o          out 1                frame in progress; strobes dropped
//   spike_count_o   out IDX_W+1          popcount of the last captured frame
//   overrun_cnt_o   out 8                saturating count of dropped strobes
module spike_packet_encoder
  import spike_packet_encoder_pkg::*;
#(
  parameter int                   NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int                   IDX_W       = DEF_IDX_W,
  parameter int                   CORE_ID_W   = DEF_CORE_ID_W,
  parameter logic [CORE_ID_W-1:0] CORE_ID     = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_NEURONS-1:0]     spike_vec_i,
  input  logic                       spike_strobe_i,
  output logic                       pkt_valid_o,
  input  logic                       pkt_ready_i,
  output logic [CORE_ID_W+IDX_W-1:0] pkt_data_o,
  output logic                       pkt_last_o,
  output logic                       frame_done_o,
  output logic                       busy_o,
  output logic [IDX_W:0]             spike_count_o,
  output logic [7:0]                 overrun_cnt_o
);

  localparam int PKT_W = CORE_ID_W + IDX_W;

  if ($clog2(NUM_NEURONS) != IDX_W) begin : g_bad_idx_w
    $error("IDX_W must equal clog2(NUM_NEURONS)");
  end

  state_t                 state_reg, state_next;
  logic [NUM_NEURONS-1:0] shadow_reg, shadow_next;
  logic [IDX_W:0]         spike_count_reg, spike_count_next;
  logic [7:0]             overrun_reg, overrun_next;
  logic                   done_reg, done_next;

  logic [IDX_W-1:0]       low_idx;
  logic                   any_set;
  logic                   single_bit;
  logic [IDX_W:0]         vec_popcount;

  spike_priority_encoder #(
    .N     (NUM_NEURONS),
    .IDX_W (IDX_W)
  ) u_prio (
    .vec     (shadow_reg),
    .idx     (low_idx),
    .any_set (any_set)
  );

  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign single_bit = ((shadow_reg & (shadow_reg - NUM_NEURONS'(1))) == '0);

  always_comb begin
    vec_popcount = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      vec_popcount = vec_popcount + (IDX_W + 1)'(spike_vec_i[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      shadow_reg      <= '0;
      spike_count_reg <= '0;
      overrun_reg     <= '0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shadow_reg      <= shadow_next;
      spike_count_reg <= spike_count_next;
      overrun_reg     <= overrun_next;
      done_reg        <= done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    shadow_next      = shadow_reg;
    spike_count_next = spike_count_reg;
    overrun_next     = overrun_reg;
    done_next        = 1'b0;
    pkt_valid_o      = 1'b0;
    pkt_last_o       = 1'b0;
    pkt_data_o       = '0;

    case (state_reg)
      IDLE: begin
        if (spike_strobe_i) begin
          shadow_next      = spike_vec_i;
          spike_count_next = vec_popcount;
          if (|spike_vec_i) begin
            state_next = SEND;
          end else begin
            // Empty frame: nothing to send, report completion next cycle.
            done_next = 1'b1;
          end
        end
      end

      SEND: begin
        pkt_valid_o                           = any_set;
        pkt_last_o                            = single_bit;
        pkt_data_o[PKT_IDX_LSB +: IDX_W]      = low_idx;
        pkt_data_o[IDX_W +: (PKT_W - IDX_W)]  = CORE_ID;

        // A strobe in SEND (including the final-handshake cycle) is dropped.
        if (spike_strobe_i && (overrun_reg != 8'hFF)) begin
          overrun_next = overrun_reg + 8'd1;
        end

        if (pkt_ready_i) begin
          shadow_next = shadow_reg & (shadow_reg - NUM_NEURONS'(1));
          if (single_bit) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy_o        = (state_reg != IDLE);
  assign frame_done_o  = done_reg;
  assign spike_count_o = spike_count_reg;
  assign overrun_cnt_o = overrun_reg;

endmodule

// File: tb/tb_spike_packet_encoder.sv
// Scoreboard bench: stimulus pushes expected {idx, last} entries, a negedge
// monitor pops and compares them whenever a packet handshake occurs. Two
// instances (CORE_ID 0x00 and 0x5A) share the stimulus; the monitor checks
// both against the same expected neuron index.
module tb_spike_packet_encoder;
  import spike_packet_encoder_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [DEF_NUM_NEURONS-1:0] spike_vec;
  logic                       spike_strobe;
  logic                       pkt_ready;

  logic                 valid0, last0, done0, busy0;
  logic [DEF_PKT_W-1:0] data0;
  logic [DEF_IDX_W:0]   count0;
  logic [7:0]           overrun0;

  logic                 valid5a, last5a, done5a, busy5a;
  logic [DEF_PKT_W-1:0] data5a;
  logic [DEF_IDX_W:0]   count5a;
  logic [7:0]           overrun5a;

  int errors = 0;
  int checks = 0;

  // Expected packet: {neuron index[8:1], last[0]}
  logic [8:0] exp_q[$];

  logic                 stall_pend = 1'b0;
  logic [DEF_PKT_W-1:0] stall_data;
  logic                 stall_last;

  always #5 clk = ~clk;

  spike_packet_encoder #(.CORE_ID(8'h00)) dut0 (
    .clk(clk), .reset(reset), .spike_vec_i(spike_vec), .spike_strobe_i(spike_strobe),
    .pkt_valid_o(valid0), .pkt_ready_i(pkt_ready), .pkt_data_o(data0), .pkt_last_o(last0),
    .frame_done_o(done0), .busy_o(busy0), .spike_count_o(count0), .overrun_cnt_o(overrun0)
  );

  spike_packet_encoder #(.CORE_ID(8'h5A)) dut5a (
    .clk(clk), .reset(reset), .spike_vec_i(spike_vec), .spike_strobe_i(spike_strobe),
    .pkt_valid_o(valid5a), .pkt_ready_i(pkt_ready), .pkt_data_o(data5a), .pkt_last_o(last5a),
    .frame_done_o(done5a), .busy_o(busy5a), .spike_count_o(count5a), .overrun_cnt_o(overrun5a)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_pkt(int idx, bit last);
    exp_q.push_back({idx[7:0], last});
  endfunction

  // Monitor: one line per accepted packet, checks against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_valid", {31'b0, valid0}, 32'd1);
        chk("stall_data", {16'b0, data0}, {16'b0, stall_data});
        chk("stall_last", {31'b0, last0}, {31'b0, stall_last});
      end
      if (valid0 || valid5a) begin
        chk("valid_pair", {31'b0, valid5a}, {31'b0, valid0});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pkt: got data0=0x%0h with no packet expected", data0);
        end else if (valid0 && pkt_ready) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          $display("pkt: data0=0x%04h data5a=0x%04h last=%0d expect idx=0x%02h last=%0d",
                   data0, data5a, last0, e[8:1], e[0]);
          chk("pkt_data0", {16'b0, data0}, {16'b0, 8'h00, e[8:1]});
          chk("pkt_data5a", {16'b0, data5a}, {16'b0, 8'h5A, e[8:1]});
          chk("pkt_last0", {31'b0, last0}, {31'b0, e[0]});
          chk("pkt_last5a", {31'b0, last5a}, {31'b0, e[0]});
        end
      end
      stall_pend = valid0 && !pkt_ready;
      stall_data = data0;
      stall_last = last0;
    end
  end

  // Drive a one-cycle strobe in cycle T; returns 1ns into cycle T+1.
  task automatic strobe(input logic [DEF_NUM_NEURONS-1:0] v);
    @(posedge clk); #1;
    spike_vec    = v;
    spike_strobe = 1'b1;
    @(posedge clk); #1;
    spike_strobe = 1'b0;
  endtask

  // Counts negedges from the current cycle until frame_done; n=1 is this cycle.
  task automatic expect_done(input string name, input int exp);
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (done0) begin
        $display("frame_done %s: after %0d cycles (expect %0d)", name, n, exp);
        chk(name, n, exp);
        chk({name, "_busy"}, {31'b0, busy0}, 32'd0);
        chk({name, "_done5a"}, {31'b0, done5a}, 32'd1);
        @(negedge clk);
        chk({name, "_pulse"}, {31'b0, done0}, 32'd0);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: frame_done never seen within 400 cycles", name);
  endtask

  task automatic drained(input string name);
    repeat (3) @(posedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DEF_NUM_NEURONS-1:0] v;
    reset        = 1'b1;
    spike_vec    = '0;
    spike_strobe = 1'b0;
    pkt_ready    = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, valid0}, 0);
    chk("rst_data", {16'b0, data0}, 0);
    chk("rst_last", {31'b0, last0}, 0);
    chk("rst_done", {31'b0, done0}, 0);
    chk("rst_busy", {31'b0, busy0}, 0);
    chk("rst_count", {23'b0, count0}, 0);
    chk("rst_overrun", {24'b0, overrun0}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Spikes {3,17,255}, ready held high
    v = '0; v[3] = 1'b1; v[17] = 1'b1; v[255] = 1'b1;
    push_pkt(3, 0); push_pkt(17, 0); push_pkt(255, 1);
    strobe(v);
    chk("t1_busy", {31'b0, busy0}, 1);
    chk("t1_count", {23'b0, count0}, 3);
    expect_done("t1_done", 4);
    drained("t1_drained");

    // Empty frame
    strobe('0);
    chk("t2_count", {23'b0, count0}, 0);
    expect_done("t2_done", 1);
    drained("t2_drained");

    // Spikes {5,6}, ready low T+1..T+5
    v = '0; v[5] = 1'b1; v[6] = 1'b1;
    push_pkt(5, 0); push_pkt(6, 1);
    pkt_ready = 1'b0;
    strobe(v);
    repeat (5) @(posedge clk);
    #1 pkt_ready = 1'b1;
    expect_done("t3_done", 3);
    chk("t3_count", {23'b0, count0}, 2);
    drained("t3_drained");

    // Strobes during SEND, one in the final-handshake cycle
    v = '0; v[10] = 1'b1; v[20] = 1'b1; v[30] = 1'b1;
    push_pkt(10, 0); push_pkt(20, 0); push_pkt(30, 1);
    strobe(v);
    spike_vec = '1; spike_strobe = 1'b1;       // T+1
    @(posedge clk); #1; spike_strobe = 1'b0;  // T+2
    @(posedge clk); #1; spike_strobe = 1'b1;  // T+3: final handshake
    @(posedge clk); #1; spike_strobe = 1'b0;  // T+4
    expect_done("t4_done", 1);
    chk("t4_overrun", {24'b0, overrun0}, 2);
    chk("t4_count", {23'b0, count0}, 3);
    drained("t4_drained");

    // Reset while 2nd of 4 packets stalls
    v = '0; v[1] = 1'b1; v[2] = 1'b1; v[3] = 1'b1; v[4] = 1'b1;
    push_pkt(1, 0); push_pkt(2, 0); push_pkt(3, 0); push_pkt(4, 1);
    strobe(v);                                 // T+1: packet 1 accepted
    @(posedge clk); #1; pkt_ready = 1'b0;      // T+2: packet 2 stalls
    @(posedge clk); #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_valid_async", {31'b0, valid0}, 0);
    chk("t5_busy_async", {31'b0, busy0}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_overrun", {24'b0, overrun0}, 0);
    chk("t5_count", {23'b0, count0}, 0);
    pkt_ready = 1'b1;
    v = '0; v[9] = 1'b1;
    push_pkt(9, 1);
    strobe(v);
    expect_done("t5_done", 2);
    drained("t5_drained");

    // All 256 bits set
    for (int i = 0; i < 256; i++) push_pkt(i, i == 255);
    strobe('1);
    chk("t6_count0", {23'b0, count0}, 256);
    chk("t6_count5a", {23'b0, count5a}, 256);
    expect_done("t6_done", 257);
    drained("t6_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
